// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencing controller for the 16-bit datapath. Each instruction
// steps through FETCH, DECODE, EXEC, MEM and WB. The controller drives the
// enables of the IR, PC, register file and memory port once per state.
//
// Parameters
//   OPW          opcode width (>= 4). Low 4 bits select the operation and
//                every upper bit must be 0, otherwise the opcode is illegal.
//   MEM_TIMEOUT  maximum mem_ready wait cycles in FETCH/MEM (0 = no watchdog).
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   opcode_i       IR opcode field, sampled in DECODE
//   mem_ready_i    completion of the current memory request
//   flag_*_i       ALU compare flags, used by branches in EXEC
//   resume_i       level-sensitive request to leave HALT
//   ir_load_o, pc_inc_o, pc_write_o    IR load, PC+2, PC load from target
//   reg_write_o, wb_mem_o              RF write enable, write-back from memory
//   imm_sel_o, offset_sel_o            ALU B = zero-ext immediate / sign-ext offset
//   mem_req_o, mem_we_o, mem_byte_o    memory request, write, byte access
//   retire_o, illegal_o                one-cycle pulses
//   halted_o, bus_err_o                status (bus_err is sticky until reset)
//   state_o                            current state, IDLE=0 .. HALT=6
//
// Memory handshake: mem_req_o is raised on entry to FETCH/MEM and held stable
// until the cycle in which mem_ready_i is high; the transfer completes and the
// state advances on that rising edge. mem_ready_i is ignored in other states.
module multicycle_control #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [OPW-1:0] opcode_i,
    input  logic           mem_ready_i,
    input  logic           flag_lt_i,
    input  logic           flag_gt_i,
    input  logic           flag_eq_i,
    input  logic           resume_i,
    output logic           ir_load_o,
    output logic           pc_inc_o,
    output logic           pc_write_o,
    output logic           reg_write_o,
    output logic           wb_mem_o,
    output logic           imm_sel_o,
    output logic           offset_sel_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic           mem_byte_o,
    output logic           retire_o,
    output logic           illegal_o,
    output logic           halted_o,
    output logic           bus_err_o,
    output logic [2:0]     state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam int  CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit  WD_EN = (MEM_TIMEOUT != 0);

    logic [2:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bus_err_q, bus_err_d;

    // In DECODE the opcode register is being loaded, so decode straight from
    // the IR; in later states use the latched copy.
    logic [OPW-1:0] cur_op;
    logic [OPW+3:0] op_ext;
    logic [3:0]     lo;
    logic           upper_nz;
    logic           is_halt, is_jmp, is_alu, is_imm, is_ld, is_st, is_br, is_ill;
    logic           is_byte, taken, timeout, in_x;

    always_comb begin
        cur_op   = (state_q == S_DECODE) ? opcode_i : op_q;
        op_ext   = {4'b0000, cur_op};
        upper_nz = |op_ext[OPW+3:4];
        lo       = cur_op[3:0];
        is_halt  = !upper_nz && (lo == 4'h0);
        is_jmp   = !upper_nz && (lo == 4'h1);
        is_alu   = !upper_nz && (lo == 4'hF);
        is_imm   = !upper_nz && (lo == 4'h8 || lo == 4'h9);
        is_ld    = !upper_nz && (lo == 4'hA || lo == 4'hC);
        is_st    = !upper_nz && (lo == 4'hB || lo == 4'hD);
        is_br    = !upper_nz && (lo == 4'h4 || lo == 4'h5 || lo == 4'h6);
        is_byte  = !upper_nz && (lo == 4'hA || lo == 4'hB);
        is_ill   = !(is_halt || is_jmp || is_alu || is_imm || is_ld || is_st || is_br);
        taken    = (lo == 4'h5 && flag_lt_i) || (lo == 4'h4 && flag_gt_i) ||
                   (lo == 4'h6 && flag_eq_i);
        // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
        timeout  = WD_EN && !mem_ready_i && (cnt_q == CW'(MEM_TIMEOUT - 1));
        in_x     = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bus_err_d   = bus_err_q;
        ir_load_o   = 1'b0;
        pc_inc_o    = 1'b0;
        pc_write_o  = 1'b0;
        reg_write_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        retire_o    = 1'b0;
        illegal_o   = 1'b0;
        halted_o    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    pc_inc_o  = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                op_d = opcode_i;
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_jmp) begin
                    pc_write_o = 1'b1;
                    retire_o   = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_ill) begin
                    illegal_o = 1'b1;
                    retire_o  = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_write_o = taken;
                    retire_o   = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = is_st;
                if (mem_ready_i) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                halted_o = 1'b1;
                if (resume_i && !bus_err_q) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand/write-back selects are only meaningful while the instruction
    // is past decode.
    assign imm_sel_o    = in_x && is_imm;
    assign offset_sel_o = in_x && (is_ld || is_st);
    assign wb_mem_o     = in_x && is_ld;
    assign mem_byte_o   = in_x && is_byte;
    assign bus_err_o    = bus_err_q;
    assign state_o      = state_q;

    // Wait counter restarts whenever the state changes, so every FETCH/MEM
    // entry begins at 0; it only advances while waiting in those states.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (WD_EN && !mem_ready_i &&
                     (state_q == S_FETCH || state_q == S_MEM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle sequencing controller for the 16-bit datapath. It replaces the purely combinational opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Memory accesses use a request/ready handshake with a timeout watchdog. It sits between the instruction register, PC, register file, ALU flags and memory port, and drives their enables once per state.

## Interface
- OPW, 4: opcode width, minimum 4; the low 4 bits select the operation and every upper bit must be 0.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready; 0 disables the watchdog.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPW  opcode field of the instruction register, sampled in DECODE.
- mem_ready  in  1  memory completion for the current mem_req.
- flag_lt, flag_gt, flag_eq  in  1 each  ALU compare flags, sampled in EXEC.
- resume  in  1  leave HALT; level-sensitive.
- ir_load, pc_inc, pc_write  out  1  IR load, PC+2, PC load from the target.
- reg_write, wb_mem  out  1  register-file write enable; write-back source is memory (1) or the ALU (0).
- imm_sel, offset_sel  out  1  ALU B operand is the zero-extended immediate / the sign-extended offset.
- mem_req, mem_we, mem_byte  out  1  memory request, write, byte access.
- retire, illegal  out  1  one-cycle pulses.
- halted, bus_err  out  1  status.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

## Operation
- Opcode classes, decoded from an internal opcode register:
  - 1111 ALU R-type; 1000 ANDi and 1001 ORi (both imm_sel).
  - 1010 LB and 1100 LW (offset_sel, wb_mem).
  - 1011 SB and 1101 SW (offset_sel).
  - 0101 BLT, 0100 BGT, 0110 BEQ.
  - 0001 JMP; 0000 HALT.
  - Any other value, or a nonzero upper opcode bit, is illegal.
- imm_sel, offset_sel, wb_mem and mem_byte are valid from EXEC through WB and are 0 elsewhere.
- IDLE: all outputs 0; next state FETCH.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_load=1, pc_inc=1, next state DECODE.
- DECODE: latch opcode.
  - HALT opcode -> HALT.
  - JMP -> pc_write=1, retire=1, next FETCH.
  - Illegal -> illegal=1, retire=1, next FETCH (executes as a NOP).
  - All others -> EXEC.
- EXEC:
  - ALU and immediate ops -> WB.
  - Loads and stores -> MEM.
  - Branches: taken if (BLT and flag_lt), (BGT and flag_gt) or (BEQ and flag_eq). Then pc_write=taken, retire=1, next FETCH.
- MEM:
  - mem_req=1, mem_we=store, mem_byte=LB/SB.
  - On mem_ready: loads -> WB; stores -> retire=1, next FETCH.
- WB: reg_write=1, retire=1, next FETCH.
- HALT:
  - halted=1.
  - resume=1 with bus_err=0 -> FETCH.
  - resume is ignored while bus_err=1.
- Watchdog:
  - A counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states.
  - When it reaches MEM_TIMEOUT: bus_err is set (sticky until reset), mem_req drops, next state HALT; the instruction does not retire.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Reset:
  - state=IDLE, opcode register=0, counter=0.
  - Every output 0 while rst is low and in IDLE.
  - Reset released -> IDLE for 1 cycle, then FETCH.
- Reset asserted mid-instruction:
  - Immediate return to IDLE; mem_req and reg_write drop asynchronously.
  - No partial retire.
- Instruction latency with mem_ready high the same cycle as request:
  - ALU/imm: 4 cycles; load: 5; store: 4; branch: 3; JMP and illegal: 2.
  - HALT: 2 cycles to the halted state.
- Memory wait: each mem_ready=0 cycle adds 1 cycle.
- mem_req is held stable until the mem_ready cycle; the transition occurs on that edge.
- Outputs are combinational from the state, opcode and flag registers. They are glitch-free relative to clk for registered inputs.
- Timeout: entering FETCH with mem_ready held low gives bus_err=1 on the cycle after the MEM_TIMEOUT-th wait cycle, with state=HALT.
- resume high on the cycle of HALT entry leaves HALT on the next edge (minimum 1 cycle halted).

## Test plan
- Reset, then ALU op 1111 with mem_ready=1 -> state sequence 0,1,2,3,5,1. Single reg_write and retire pulses in cycle 5; wb_mem=0.
- LW 1100 with mem_ready delayed 3 cycles in MEM -> MEM lasts 4 cycles, mem_we=0, mem_byte=0, then WB with wb_mem=1. SB 1011 -> mem_we=1, mem_byte=1, no reg_write.
- BEQ 0110:
  - flag_eq=1 -> pc_write=1 in EXEC.
  - flag_eq=0 with flag_lt=1 -> pc_write=0.
  - BLT 0101 with flag_lt=1 -> pc_write=1.
  - JMP 0001 -> pc_write in DECODE.
- Opcode 0011, and opcode 0x1F with OPW=5 -> illegal pulse, retire, return to FETCH; no reg_write or mem_req.
- HALT 0000 -> halted=1 held while resume=0; resume=1 -> FETCH the next cycle.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> bus_err=1 and HALT after 4 wait cycles; resume ignored; cleared only by rst=0.
